// File: rtl/wma_inverse.sv
// Inverse of the transposed-form weighted moving average encoder:
// recovers x[n] from y[n] using the last three recovered samples.
module wma_inverse #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] y_in,
    input  logic         y_valid,
    input  logic         flush,
    output logic [N-1:0] x_out,
    output logic         x_valid,
    output logic         primed,
    output logic [7:0]   sample_cnt
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FILL1  = 2'd1,
        FILL2  = 2'd2,
        PRIMED = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] x_out_q, x_out_d;
    logic         x_valid_q, x_valid_d;
    logic [N-1:0] h1_q, h1_d;
    logic [N-1:0] h2_q, h2_d;
    logic [N-1:0] h3_q, h3_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [N-1:0] x_hat_s;

    // Deconvolution, history shift, fill-state tracking and sample counting
    always_comb begin
        state_d   = state_q;
        x_out_d   = x_out_q;
        x_valid_d = 1'b0;
        h1_d      = h1_q;
        h2_d      = h2_q;
        h3_d      = h3_q;
        cnt_d     = cnt_q;
        // Subtractions wrap modulo 2^N, matching the encoder's wrapping adds
        x_hat_s   = y_in - (h1_q >> 1'd1) - (h2_q >> 2'd2) - (h3_q >> 2'd3);

        if (flush) begin
            state_d = EMPTY;
            x_out_d = '0;
            h1_d    = '0;
            h2_d    = '0;
            h3_d    = '0;
            cnt_d   = 8'd0;
        end else if (y_valid) begin
            x_out_d   = x_hat_s;
            x_valid_d = 1'b1;
            h1_d      = x_hat_s;
            h2_d      = h1_q;
            h3_d      = h2_q;
            if (cnt_q != 8'd255) begin
                cnt_d = cnt_q + 8'd1;
            end else begin
                cnt_d = cnt_q;
            end
            case (state_q)
                EMPTY:   state_d = FILL1;
                FILL1:   state_d = FILL2;
                FILL2:   state_d = PRIMED;
                PRIMED:  state_d = PRIMED;
                default: state_d = EMPTY;
            endcase
        end else begin
            x_valid_d = 1'b0;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            x_out_q   <= '0;
            x_valid_q <= 1'b0;
            h1_q      <= '0;
            h2_q      <= '0;
            h3_q      <= '0;
            cnt_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            x_out_q   <= x_out_d;
            x_valid_q <= x_valid_d;
            h1_q      <= h1_d;
            h2_q      <= h2_d;
            h3_q      <= h3_d;
            cnt_q     <= cnt_d;
        end
    end

    assign x_out      = x_out_q;
    assign x_valid    = x_valid_q;
    assign primed     = (state_q == PRIMED);
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_wma_inverse.sv
// Scoreboard bench for wma_inverse (N=4): directed scenarios plus encoder loopback.
module tb_wma_inverse;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] y_in;
    logic         y_valid;
    logic         flush;
    logic [N-1:0] x_out;
    logic         x_valid;
    logic         primed;
    logic [7:0]   sample_cnt;

    int tests_run = 0;
    int fail_cnt  = 0;
    logic [N-1:0] exp_q[$];

    wma_inverse #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .y_in       (y_in),
        .y_valid    (y_valid),
        .flush      (flush),
        .x_out      (x_out),
        .x_valid    (x_valid),
        .primed     (primed),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush   = 1'b1;
        y_valid = 1'b0;
        step();
        flush   = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; y_valid = 1'b0; flush = 1'b0; y_in = '0;
        step();
        step();
        tests_run++;
        if ({x_out, x_valid, primed, sample_cnt} !== 15'd0) begin
            fail_cnt++;
            $display("FAIL reset: x_out=%0d x_valid=%0b primed=%0b cnt=%0d, want all 0",
                     x_out, x_valid, primed, sample_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_impulse();
        logic [N-1:0] ys [4] = '{4'd8, 4'd4, 4'd2, 4'd1};
        logic [N-1:0] xs [4] = '{4'd8, 4'd0, 4'd0, 4'd0};
        logic [N-1:0] got;
        do_flush();
        for (int i = 0; i < 4; i++) begin
            y_in = ys[i]; y_valid = 1'b1;
            exp_q.push_back(xs[i]);
            step();
            tests_run++;
            got = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
            if (x_valid !== 1'b1 || x_out !== got) begin
                fail_cnt++;
                $display("FAIL impulse[%0d]: x_out=%0d x_valid=%0b, want %0d valid", i, x_out, x_valid, got);
            end
            tests_run++;
            if (primed !== (i >= 2) || sample_cnt !== 8'(i + 1)) begin
                fail_cnt++;
                $display("FAIL impulse_primed[%0d]: primed=%0b cnt=%0d, want %0b %0d", i, primed, sample_cnt, (i >= 2), i + 1);
            end
        end
        y_valid = 1'b0;
        step();
        tests_run++;
        if (x_valid !== 1'b0 || x_out !== 4'd0) begin
            fail_cnt++;
            $display("FAIL impulse_idle: x_valid=%0b x_out=%0d, want 0 0", x_valid, x_out);
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] ys [2] = '{4'd15, 4'd6};
        logic [N-1:0] got;
        do_flush();
        for (int i = 0; i < 2; i++) begin
            y_in = ys[i]; y_valid = 1'b1;
            exp_q.push_back(4'd15);
            step();
            tests_run++;
            got = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
            if (x_valid !== 1'b1 || x_out !== got) begin
                fail_cnt++;
                $display("FAIL wrap[%0d]: x_out=%0d x_valid=%0b, want %0d valid", i, x_out, x_valid, got);
            end
        end
        y_valid = 1'b0;
    endtask

    task automatic test_gaps();
        do_flush();
        y_in = 4'd8; y_valid = 1'b1;
        step();
        tests_run++;
        if (x_valid !== 1'b1 || x_out !== 4'd8) begin
            fail_cnt++;
            $display("FAIL gap_first: x_out=%0d x_valid=%0b, want 8 valid", x_out, x_valid);
        end
        y_valid = 1'b0; y_in = 4'd13;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (x_valid !== 1'b0 || x_out !== 4'd8) begin
                fail_cnt++;
                $display("FAIL gap_hold[%0d]: x_out=%0d x_valid=%0b, want 8 invalid", i, x_out, x_valid);
            end
        end
        y_in = 4'd4; y_valid = 1'b1;
        step();
        tests_run++;
        if (x_valid !== 1'b1 || x_out !== 4'd0) begin
            fail_cnt++;
            $display("FAIL gap_second: x_out=%0d x_valid=%0b, want 0 valid", x_out, x_valid);
        end
        y_valid = 1'b0;
    endtask

    task automatic test_flush_priority();
        logic [N-1:0] ys [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        logic [N-1:0] xs [5] = '{4'd1, 4'd2, 4'd2, 4'd3, 4'd4};
        logic [N-1:0] got;
        do_flush();
        for (int i = 0; i < 5; i++) begin
            y_in = ys[i]; y_valid = 1'b1;
            exp_q.push_back(xs[i]);
            step();
            tests_run++;
            got = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
            if (x_valid !== 1'b1 || x_out !== got) begin
                fail_cnt++;
                $display("FAIL prefill[%0d]: x_out=%0d x_valid=%0b, want %0d valid", i, x_out, x_valid, got);
            end
        end
        flush = 1'b1; y_in = 4'd9; y_valid = 1'b1;
        step();
        tests_run++;
        if (x_valid !== 1'b0 || sample_cnt !== 8'd0 || primed !== 1'b0 || x_out !== 4'd0) begin
            fail_cnt++;
            $display("FAIL flush_prio: x_valid=%0b cnt=%0d primed=%0b x_out=%0d, want 0 0 0 0",
                     x_valid, sample_cnt, primed, x_out);
        end
        flush = 1'b0; y_in = 4'd3; y_valid = 1'b1;
        step();
        tests_run++;
        if (x_valid !== 1'b1 || x_out !== 4'd3 || sample_cnt !== 8'd1) begin
            fail_cnt++;
            $display("FAIL after_flush: x_out=%0d x_valid=%0b cnt=%0d, want 3 valid 1", x_out, x_valid, sample_cnt);
        end
        y_valid = 1'b0;
    endtask

    // Encoder modelled as a registered stage: y computed from x at iteration i is presented at i+1
    task automatic test_back_to_back();
        logic [N-1:0] e1, e2, e3, xn, yn, prev_y, got;
        logic         prev_v;
        e1 = '0; e2 = '0; e3 = '0; prev_y = '0; prev_v = 1'b0;
        do_flush();
        for (int i = 0; i <= 1000; i++) begin
            y_in = prev_y; y_valid = prev_v;
            if (i < 1000) begin
                xn = 4'($urandom_range(0, 15));
                yn = xn + (e1 >> 1) + (e2 >> 2) + (e3 >> 3);
                exp_q.push_back(xn);
                e3 = e2; e2 = e1; e1 = xn;
                prev_y = yn; prev_v = 1'b1;
            end else begin
                prev_v = 1'b0;
            end
            step();
            if (i >= 1) begin
                tests_run++;
                got = (exp_q.size() > 0) ? exp_q.pop_front() : 4'd0;
                if (x_valid !== 1'b1 || x_out !== got) begin
                    fail_cnt++;
                    $display("FAIL loopback[%0d]: x_out=%0d x_valid=%0b, want %0d valid", i, x_out, x_valid, got);
                end
            end
        end
        y_valid = 1'b0;
        tests_run++;
        if (sample_cnt !== 8'd255 || primed !== 1'b1) begin
            fail_cnt++;
            $display("FAIL saturate: cnt=%0d primed=%0b, want 255 1", sample_cnt, primed);
        end
    endtask

    task automatic test_async_reset();
        do_flush();
        y_in = 4'd7; y_valid = 1'b1;
        step();
        y_in = 4'd3;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({x_out, x_valid, primed, sample_cnt} !== 15'd0) begin
            fail_cnt++;
            $display("FAIL async_rst: x_out=%0d x_valid=%0b primed=%0b cnt=%0d, want all 0",
                     x_out, x_valid, primed, sample_cnt);
        end
        step();
        tests_run++;
        if (x_valid !== 1'b0) begin
            fail_cnt++;
            $display("FAIL inflight: x_valid=%0b, want 0", x_valid);
        end
        rst = 1'b0; y_valid = 1'b0;
        exp_q.delete();
        step();
        y_in = 4'd5; y_valid = 1'b1;
        step();
        tests_run++;
        if (x_valid !== 1'b1 || x_out !== 4'd5 || sample_cnt !== 8'd1) begin
            fail_cnt++;
            $display("FAIL post_rst: x_out=%0d x_valid=%0b cnt=%0d, want 5 valid 1", x_out, x_valid, sample_cnt);
        end
        y_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_wrap();
        test_gaps();
        test_flush_priority();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end
endmodule
